// File: rtl/reg_file_if.sv
// -----------------------------------------------------------------------------
// reg_file_if : write/read bus bundle for reg_file (one write port, two read ports)
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

interface reg_file_if #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
);
   logic             We;
   logic [AW-1:0]    Wn;
   logic [WIDTH-1:0] D;
   logic [AW-1:0]    Rna;
   logic [AW-1:0]    Rnb;
   logic [WIDTH-1:0] Qa;
   logic [WIDTH-1:0] Qb;

   modport master (
      output We, Wn, D, Rna, Rnb,
      input  Qa, Qb
   );

   modport slave (
      input  We, Wn, D, Rna, Rnb,
      output Qa, Qb
   );
endinterface

`default_nettype wire

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file : 2**AW x WIDTH register file, register 0 hard-wired to zero,
//            async-cleared flops, two combinational read ports, no bypass
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module reg_file #(
   parameter int WIDTH = 32,
   parameter int AW    = 5
) (
   input  wire logic  Clk,
   input  wire logic  Rst,
   reg_file_if.slave  bus
);
   localparam int c_NREG = 2 ** AW;

   logic [WIDTH-1:0] regs_q [c_NREG];
   logic [WIDTH-1:0] regs_d [c_NREG];

   // Write-enable mux sits in front of D; entry 0 is forced to zero so it never changes.
   always_comb begin
      for (int i = 0; i < c_NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (bus.We && (bus.Wn != '0)) begin
         regs_d[bus.Wn] = bus.D;
      end
      regs_d[0] = '0;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < c_NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < c_NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Reads come straight from the flops: a same-cycle write is visible only after the edge.
   assign bus.Qa = regs_q[bus.Rna];
   assign bus.Qb = regs_q[bus.Rnb];
endmodule

`default_nettype wire

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width of every register and data port.
REQ-002 The block SHALL have parameter AW, default 5, meaning register address width; register count = 2**AW (32 at default).
REQ-003 The block SHALL have port Clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port We  input  1  write enable, sampled at rising Clk.
REQ-006 The block SHALL have port Wn  input  AW  write register number.
REQ-007 The block SHALL have port D  input  WIDTH  write data.
REQ-008 The block SHALL have port Rna  input  AW  read port A register number.
REQ-009 The block SHALL have port Rnb  input  AW  read port B register number.
REQ-010 The block SHALL have port Qa  output  WIDTH  read port A data.
REQ-011 The block SHALL have port Qb  output  WIDTH  read port B data.

Function
REQ-012 The block SHALL hold 2**AW registers of WIDTH bits; register 0 SHALL be constant zero.
REQ-013 At a rising Clk with Rst=0, We=1 and Wn!=0, register[Wn] SHALL take D; all other registers SHALL hold.
REQ-014 At a rising Clk with We=0, or with Wn=0, no register SHALL change.
REQ-015 Qa SHALL equal register[Rna] and Qb SHALL equal register[Rnb], combinationally, with zero-cycle latency; Rna=0 or Rnb=0 SHALL give 0.
REQ-016 Both read ports SHALL be fully independent; Rna=Rnb SHALL give Qa=Qb.
REQ-017 Read/write collision (Rna or Rnb equal to Wn, We=1): before the edge, the read port SHALL show the old value; from the edge onward it SHALL show D. There is no write-through bypass.
REQ-018 Back-to-back writes to the same register on consecutive edges SHALL each take effect; the last write wins.
REQ-019 X or Z on Rna/Rnb SHALL not corrupt stored state. X on We SHALL be treated as a protocol error; the bench flags it.
REQ-020 Each register bit SHALL be an edge-triggered D flip-flop with asynchronous clear. The write-enable mux SHALL be in front of D, not a gated clock.

Reset
REQ-021 While Rst=1, all registers SHALL be 0 immediately, independent of Clk. Qa=Qb=0 for any Rna/Rnb.
REQ-022 A write edge coinciding with Rst=1 SHALL be ignored; reset dominates.
REQ-023 Rst asserted mid-operation SHALL clear all registers within the same simulation time step. The first write SHALL take effect on the first rising Clk after Rst falls.

Verification
REQ-024 The bench SHALL run: Rst=1 with Clk stopped, Rna=5, Rnb=31 -> Qa=Qb=0 with no clock edge.
REQ-025 The bench SHALL run: for each n in 1..31, write D=n*32'h01010101, then read via A and B -> Qa=Qb=n*32'h01010101; register 0 reads 0.
REQ-026 The bench SHALL run: We=1, Wn=0, D=32'hFFFFFFFF, then Rna=0 -> Qa=0.
REQ-027 The bench SHALL run: register 7 holds 32'h11111111; We=1, Wn=7, D=32'h22222222, Rna=7 -> Qa=32'h11111111 before the edge and 32'h22222222 after it.
REQ-028 The bench SHALL run: We=0, Wn=3, D=32'hDEADBEEF with register 3 = 32'h5 -> register 3 stays 32'h5.
REQ-029 The bench SHALL run: registers 1..31 loaded, Rst pulsed for 10ns between edges -> all reads = 0 immediately. A subsequent write of 32'hA5A5A5A5 to register 9 -> Qa=32'hA5A5A5A5 after the next edge.
